// File: rtl/dsp_alu_pkg.sv
// Shared types and function codes for the DSP ALU operand sequencer.
// The {M,S} codes match the 74181-style slice used in the datapath.
package dsp_alu_pkg;

   localparam int DSP_HALF_W = 16;
   localparam int DSP_W      = 2 * DSP_HALF_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2,
      S_DONE = 2'd3
   } dsp_alu_state_e;

   // {M,S[3:0]} function selects
   localparam logic [4:0] OP_ADD   = 5'b0_1001;
   localparam logic [4:0] OP_SUB   = 5'b0_0110;
   localparam logic [4:0] OP_XOR   = 5'b1_0110;
   localparam logic [4:0] OP_AND   = 5'b1_1011;
   localparam logic [4:0] OP_OR    = 5'b1_1110;
   localparam logic [4:0] OP_PASSA = 5'b1_1111;
   localparam logic [4:0] OP_PASSB = 5'b1_1010;

   typedef struct packed {
      logic [4:0]       op;
      logic             dbl;
      logic             cil;
      logic [DSP_W-1:0] a;
      logic [DSP_W-1:0] b;
   } dsp_alu_cmd_t;

endpackage

// File: rtl/dsp_alu_if.sv
// Command and result handshake bundle between the issue logic and the ALU sequencer.
// master = command producer / result consumer, slave = sequencer.
interface dsp_alu_if
   import dsp_alu_pkg::*;
#(
   parameter int HALF_W = DSP_HALF_W
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [4:0]          cmd_op;
   logic                cmd_dbl;
   logic                cmd_cil;
   logic [2*HALF_W-1:0] cmd_a;
   logic [2*HALF_W-1:0] cmd_b;

   logic                res_valid;
   logic                res_ready;
   logic [2*HALF_W-1:0] res_z;
   logic                res_co;
   logic                res_aeb;
   logic                res_zero;

   modport master (
      output cmd_valid, cmd_op, cmd_dbl, cmd_cil, cmd_a, cmd_b,
      input  cmd_ready,
      input  res_valid, res_z, res_co, res_aeb, res_zero,
      output res_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_dbl, cmd_cil, cmd_a, cmd_b,
      output cmd_ready,
      output res_valid, res_z, res_co, res_aeb, res_zero,
      input  res_ready
   );
endinterface

// File: rtl/dsp_alu_seq.sv
// Operand sequencer and result stage around a combinational 16-bit ALU slice.
// Double-width ops run as a low pass then a high pass with the carry chained through a register.
module dsp_alu_seq
   import dsp_alu_pkg::*;
#(
   parameter int HALF_W = 16,
   parameter bit DBL_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   dsp_alu_if.slave          bus,
   output logic [HALF_W-1:0] alu_a,
   output logic [HALF_W-1:0] alu_b,
   output logic [3:0]        alu_s,
   output logic              alu_m,
   output logic              alu_cil,
   input  logic [HALF_W-1:0] alu_z,
   input  logic              alu_co,
   input  logic              alu_aeb
);

   localparam logic [1:0] ST_IDLE = S_IDLE;
   localparam logic [1:0] ST_LO   = S_LO;
   localparam logic [1:0] ST_HI   = S_HI;
   localparam logic [1:0] ST_DONE = S_DONE;

   logic [1:0]          state_reg, state_next;
   dsp_alu_cmd_t        cmd_reg;
   logic                hi_sel_reg;
   logic                co_lo_reg;
   logic                aeb_lo_reg;
   logic [HALF_W-1:0]   z_lo_reg;
   logic [2*HALF_W-1:0] res_z_reg;
   logic                res_co_reg;
   logic                res_aeb_reg;
   logic                res_zero_reg;
   logic                accept;
   logic                dbl_in;

   assign bus.cmd_ready = (state_reg == ST_IDLE) |
                          ((state_reg == ST_DONE) & bus.res_ready);
   assign accept        = bus.cmd_valid & bus.cmd_ready;
   assign dbl_in        = bus.cmd_dbl & DBL_EN;

   // ALU drive comes straight from the latched command, so it holds in IDLE/DONE
   assign alu_a   = hi_sel_reg ? cmd_reg.a[2*HALF_W-1:HALF_W] : cmd_reg.a[HALF_W-1:0];
   assign alu_b   = hi_sel_reg ? cmd_reg.b[2*HALF_W-1:HALF_W] : cmd_reg.b[HALF_W-1:0];
   assign alu_s   = cmd_reg.op[3:0];
   assign alu_m   = cmd_reg.op[4];
   assign alu_cil = hi_sel_reg ? co_lo_reg : cmd_reg.cil;

   assign bus.res_valid = (state_reg == ST_DONE);
   assign bus.res_z     = res_z_reg;
   assign bus.res_co    = res_co_reg;
   assign bus.res_aeb   = res_aeb_reg;
   assign bus.res_zero  = res_zero_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (accept) state_next = ST_LO;
         ST_LO:   state_next = cmd_reg.dbl ? ST_HI : ST_DONE;
         ST_HI:   state_next = ST_DONE;
         ST_DONE: if (bus.res_ready) state_next = accept ? ST_LO : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         cmd_reg      <= '{op: '0, dbl: 1'b0, cil: 1'b1, a: '0, b: '0};
         hi_sel_reg   <= 1'b0;
         co_lo_reg    <= 1'b1;
         aeb_lo_reg   <= 1'b0;
         z_lo_reg     <= '0;
         res_z_reg    <= '0;
         res_co_reg   <= 1'b1;
         res_aeb_reg  <= 1'b0;
         res_zero_reg <= 1'b0;
      end else begin
         state_reg <= state_next;

         if (accept) begin
            cmd_reg    <= '{op: bus.cmd_op, dbl: dbl_in, cil: bus.cmd_cil,
                            a: bus.cmd_a, b: bus.cmd_b};
            hi_sel_reg <= 1'b0;
         end

         if (state_reg == ST_LO) begin
            if (cmd_reg.dbl) begin
               // Low pass carry-out becomes the high pass carry-in, also in logic mode
               z_lo_reg   <= alu_z;
               co_lo_reg  <= alu_co;
               aeb_lo_reg <= alu_aeb;
               hi_sel_reg <= 1'b1;
            end else begin
               res_z_reg    <= {{HALF_W{1'b0}}, alu_z};
               res_co_reg   <= alu_co;
               res_aeb_reg  <= alu_aeb;
               res_zero_reg <= ~|alu_z;
            end
         end

         if (state_reg == ST_HI) begin
            res_z_reg    <= {alu_z, z_lo_reg};
            res_co_reg   <= alu_co;
            res_aeb_reg  <= aeb_lo_reg & alu_aeb;
            res_zero_reg <= ~|{alu_z, z_lo_reg};
         end
      end
   end

endmodule

// File: tb/tb_dsp_alu_seq.sv
// Directed bench for dsp_alu_seq with a behavioural 74181-style ALU slice (active-low carry).
module tb_dsp_alu_seq;
   import dsp_alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] alu_a, alu_b, alu_z;
   logic [3:0]  alu_s;
   logic        alu_m, alu_cil, alu_co, alu_aeb;
   logic [16:0] sum;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dsp_alu_if #(.HALF_W(16)) bus ();

   dsp_alu_seq #(.HALF_W(16), .DBL_EN(1'b1)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_s   (alu_s),
      .alu_m   (alu_m),
      .alu_cil (alu_cil),
      .alu_z   (alu_z),
      .alu_co  (alu_co),
      .alu_aeb (alu_aeb)
   );

   // ALU slice stand-in: arithmetic carry is active low, logic ops report CO=1
   always_comb begin
      sum     = '0;
      alu_z   = '0;
      alu_co  = 1'b1;
      alu_aeb = (alu_a == alu_b);
      case ({alu_m, alu_s})
         OP_ADD: begin
            sum    = {1'b0, alu_a} + {1'b0, alu_b} + {16'b0, ~alu_cil};
            alu_z  = sum[15:0];
            alu_co = ~sum[16];
         end
         OP_SUB: begin
            sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'b0, ~alu_cil};
            alu_z  = sum[15:0];
            alu_co = ~sum[16];
         end
         OP_XOR:   alu_z = alu_a ^ alu_b;
         OP_AND:   alu_z = alu_a & alu_b;
         OP_OR:    alu_z = alu_a | alu_b;
         OP_PASSA: alu_z = alu_a;
         OP_PASSB: alu_z = alu_b;
         default:  alu_z = '0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Called at a negedge; returns at the negedge following the accepting posedge (cycle 1)
   task automatic send(input logic [4:0] op, input logic dbl, input logic cil,
                       input logic [31:0] a, input logic [31:0] b);
      int waited = 0;
      bus.cmd_op    = op;
      bus.cmd_dbl   = dbl;
      bus.cmd_cil   = cil;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("accept", 32'(bus.cmd_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   // At cycle 1 after accept: res_valid must first rise at cycle lat, then flags are checked
   task automatic res_check(input string tag, input int lat, input logic [31:0] z,
                            input logic co, input logic aeb, input logic zero);
      for (int k = 1; k < lat; k++) begin
         check({tag, "_early"}, 32'(bus.res_valid), 32'd0);
         @(negedge clk);
      end
      check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
      check({tag, "_z"},     bus.res_z,           z);
      check({tag, "_co"},    32'(bus.res_co),     32'(co));
      check({tag, "_aeb"},   32'(bus.res_aeb),    32'(aeb));
      check({tag, "_zero"},  32'(bus.res_zero),   32'(zero));
      $display("txn %-6s z=%h co=%b aeb=%b zero=%b", tag, bus.res_z, bus.res_co,
               bus.res_aeb, bus.res_zero);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_dbl   = 1'b0;
      bus.cmd_cil   = 1'b0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.res_ready = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_valid", 32'(bus.res_valid), 32'd0);
      check("rst_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_z",     bus.res_z,           32'd0);
      check("rst_co",    32'(bus.res_co),     32'd1);
      check("rst_aeb",   32'(bus.res_aeb),    32'd0);
      check("rst_zero",  32'(bus.res_zero),   32'd0);
      check("rst_alu",   {alu_a, alu_b},      32'd0);
      check("rst_cil",   32'(alu_cil),        32'd1);
      $display("txn reset");
      reset = 1'b0;
      @(negedge clk);

      // Single ADD
      send(OP_ADD, 1'b0, 1'b1, 32'h0000_1234, 32'h0000_0001);
      res_check("add", 2, 32'h0000_1235, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("add_retire", 32'(bus.res_valid), 32'd0);

      // Double ADD with carry out of the low half
      send(OP_ADD, 1'b1, 1'b1, 32'h0000_FFFF, 32'h0000_0001);
      check("dadd_lo_a",  32'(alu_a),          32'h0000_FFFF);
      check("dadd_lo_z",  32'(alu_z),          32'h0000_0000);
      check("dadd_lo_co", 32'(alu_co),         32'd0);
      check("dadd_lo_v",  32'(bus.res_valid),  32'd0);
      @(negedge clk);
      check("dadd_hi_cil", 32'(alu_cil),       32'd0);
      check("dadd_hi_a",   32'(alu_a),         32'h0000_0000);
      check("dadd_hi_v",   32'(bus.res_valid), 32'd0);
      @(negedge clk);
      res_check("dadd", 1, 32'h0001_0000, 1'b1, 1'b0, 1'b0);
      @(negedge clk);

      // Single SUB with a non-zero and a zero result
      send(OP_SUB, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0003);
      res_check("sub", 2, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      send(OP_SUB, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0003);
      res_check("subeq", 2, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
      @(negedge clk);

      // Logic mode XOR; upper operand bits must be ignored for a single op
      send(OP_XOR, 1'b0, 1'b1, 32'hABCD_F0F0, 32'h1234_FF00);
      res_check("xor", 2, 32'h0000_0FF0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);

      // Backpressure, then retire and accept on the same edge
      bus.res_ready = 1'b0;
      send(OP_ADD, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0002);
      res_check("bp", 2, 32'h0000_0003, 1'b1, 1'b0, 1'b0);
      bus.cmd_op    = OP_AND;
      bus.cmd_dbl   = 1'b0;
      bus.cmd_cil   = 1'b1;
      bus.cmd_a     = 32'h0000_0FF0;
      bus.cmd_b     = 32'h0000_00FF;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_v",     32'(bus.res_valid), 32'd1);
         check("bp_hold_z",     bus.res_z,           32'h0000_0003);
         check("bp_hold_ready", 32'(bus.cmd_ready), 32'd0);
      end
      bus.res_ready = 1'b1;
      #1;
      check("b2b_ready", 32'(bus.cmd_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      res_check("and", 2, 32'h0000_00F0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("and_retire", 32'(bus.res_valid), 32'd0);

      // Reset during the high pass aborts the op
      send(OP_PASSA, 1'b1, 1'b1, 32'h1234_5678, 32'h0000_0000);
      check("rhi_lo_a", 32'(alu_a), 32'h0000_5678);
      @(negedge clk);
      check("rhi_hi_a", 32'(alu_a), 32'h0000_1234);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rhi_valid", 32'(bus.res_valid), 32'd0);
      check("rhi_ready", 32'(bus.cmd_ready), 32'd1);
      check("rhi_z",     bus.res_z,           32'd0);
      check("rhi_co",    32'(bus.res_co),     32'd1);
      check("rhi_cil",   32'(alu_cil),        32'd1);
      check("rhi_alu_a", 32'(alu_a),          32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rhi_no_res", 32'(bus.res_valid), 32'd0);
      end
      $display("txn reset_in_hi");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
